// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
//   Frame format: 1 start bit, DATA_BITS data bits sent LSB first, optional
//   odd/even parity bit, then STOP_BITS stop bits.
//   Each bit is decided by a majority vote over three samples taken around
//   the bit centre.
//   Parity errors, framing errors and line breaks are reported per frame.
// Ports:
//   i_Clock      - single clock
//   i_Reset      - synchronous, active-high reset
//   i_Rx_Serial  - asynchronous serial line, idle high
//   o_Rx_DV      - one-cycle pulse when a frame completes
//   o_Rx_Byte    - received data, held until the next o_Rx_DV
//   o_Parity_Err - parity mismatch on the last frame (held)
//   o_Frame_Err  - a stop bit sampled low on the last frame (held)
//   o_Break      - last frame was all zeros with a low first stop bit (held)
//   o_Busy       - high whenever the receiver is not idle
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 12,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 8
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(CLKS_PER_BIT - 3);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = 1'(PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_CLEANUP   = 3'd5,
    S_WAIT_IDLE = 3'd6
  } state_t;

  // Majority of three samples.
  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The parity bit must make XOR(data, parity) equal 1 for odd and 0 for even.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != PAR_ODD;
  endfunction

  logic                 rx_meta_q, rx_s_q;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_q, ferr_d;
  logic                 stop0_zero_q, stop0_zero_d;
  logic                 rx_dv_q, rx_dv_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 brk_out_q, brk_out_d;
  logic                 busy_q, busy_d;
  logic                 decide_s;
  logic                 vote_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, frame capture and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      samp_q       <= 2'b00;
      data_q       <= '0;
      par_bit_q    <= 1'b0;
      ferr_q       <= 1'b0;
      stop0_zero_q <= 1'b0;
      rx_dv_q      <= 1'b0;
      rx_byte_q    <= '0;
      perr_out_q   <= 1'b0;
      ferr_out_q   <= 1'b0;
      brk_out_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      samp_q       <= samp_d;
      data_q       <= data_d;
      par_bit_q    <= par_bit_d;
      ferr_q       <= ferr_d;
      stop0_zero_q <= stop0_zero_d;
      rx_dv_q      <= rx_dv_d;
      rx_byte_q    <= rx_byte_d;
      perr_out_q   <= perr_out_d;
      ferr_out_q   <= ferr_out_d;
      brk_out_q    <= brk_out_d;
      busy_q       <= busy_d;
    end
  end

  // Bit decision happens on the last count of each bit, using the two
  // earlier samples plus the current synchronised line value.
  assign decide_s = (cnt_q == CNT_LAST);
  assign vote_s   = vote3(samp_q[0], samp_q[1], rx_s_q);

  // Next-state logic, sampling and output update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    samp_d       = samp_q;
    data_d       = data_q;
    par_bit_d    = par_bit_q;
    ferr_d       = ferr_q;
    stop0_zero_d = stop0_zero_q;
    rx_dv_d      = 1'b0;
    rx_byte_d    = rx_byte_q;
    perr_out_d   = perr_out_q;
    ferr_out_d   = ferr_out_q;
    brk_out_d    = brk_out_q;

    if (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP) begin
      if (cnt_q == CNT_S0) begin
        samp_d[0] = rx_s_q;
      end else if (cnt_q == CNT_S1) begin
        samp_d[1] = rx_s_q;
      end else begin
        samp_d = samp_q;
      end
    end else begin
      samp_d = samp_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d        = '0;
        bit_idx_d    = '0;
        stop_idx_d   = 1'b0;
        ferr_d       = 1'b0;
        stop0_zero_d = 1'b0;
        if (!rx_s_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        // Re-check the line at the middle of the start bit; a high level
        // here means the falling edge was only a glitch.
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (decide_s) begin
          cnt_d = '0;
          // Shifting in from the top leaves the first bit in the LSB.
          data_d = {vote_s, data_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (decide_s) begin
          cnt_d     = '0;
          par_bit_d = vote_s;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (decide_s) begin
          cnt_d = '0;
          if (!vote_s) begin
            ferr_d = 1'b1;
          end else begin
            ferr_d = ferr_q;
          end
          if (stop_idx_q == 1'b0) begin
            stop0_zero_d = ~vote_s;
          end else begin
            stop0_zero_d = stop0_zero_q;
          end
          if (stop_idx_q == STOP_LAST) begin
            // Outputs are loaded here so they are valid during CLEANUP,
            // the cycle in which o_Rx_DV is high.
            stop_idx_d = 1'b0;
            state_d    = S_CLEANUP;
            rx_dv_d    = 1'b1;
            rx_byte_d  = data_q;
            perr_out_d = (PARITY != 0) && parity_error(data_q, par_bit_q);
            ferr_out_d = ferr_d;
            brk_out_d  = (data_q == '0) && ((PARITY == 0) || !par_bit_q) && stop0_zero_d;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CLEANUP: begin
        // After a framing error the line may still be low (break); wait for
        // it to return high so a held break yields only one frame.
        if (ferr_q) begin
          state_d = S_WAIT_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_Rx_DV      = rx_dv_q;
  assign o_Rx_Byte    = rx_byte_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  assign o_Break      = brk_out_q;
  assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) at 12 clocks
// per bit. Expected frames are queued when sent; a monitor on the falling
// clock edge pops and compares whenever an instance pulses o_Rx_DV, and also
// services queued level probes (reset state, busy).
module tb_uart_rx_cfg;

  localparam int C = 12;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  typedef struct {
    string       name;
    int          id;
    logic [31:0] exp;
  } probe_t;

  logic clk;
  logic rst;
  logic rx0, rx1, rx2;

  logic       dv0, pe0, fe0, brk0, busy0;
  logic [7:0] byte0;
  logic       dv1, pe1, fe1, brk1, busy1;
  logic [7:0] byte1;
  logic       dv2, pe2, fe2, brk2, busy2;
  logic [6:0] byte2;

  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   q2[$];
  probe_t probe_q[$];
  exp_t   e0, e1, e2;
  probe_t pr;

  int checks = 0;
  int errors = 0;

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CNT_W(8)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx0),
    .o_Rx_DV(dv0), .o_Rx_Byte(byte0), .o_Parity_Err(pe0),
    .o_Frame_Err(fe0), .o_Break(brk0), .o_Busy(busy0)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CNT_W(8)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx1),
    .o_Rx_DV(dv1), .o_Rx_Byte(byte1), .o_Parity_Err(pe1),
    .o_Frame_Err(fe1), .o_Break(brk1), .o_Busy(busy1)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CNT_W(8)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx2),
    .o_Rx_DV(dv2), .o_Rx_Byte(byte2), .o_Parity_Err(pe2),
    .o_Frame_Err(fe2), .o_Break(brk2), .o_Busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] probe_val(input int id);
    case (id)
      0:       return {19'd0, dv0, byte0, pe0, fe0, brk0, busy0};
      1:       return {31'd0, busy2};
      2:       return {31'd0, busy0};
      3:       return 32'(q0.size() + q1.size() + q2.size());
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor / scoreboard: level probes first, then any completed frames.
  always @(negedge clk) begin
    while (probe_q.size() > 0) begin
      pr = probe_q.pop_front();
      cmp(pr.name, probe_val(pr.id), pr.exp);
    end
    if (dv0) begin
      if (q0.size() == 0) begin
        cmp("u0_unexpected_dv_pending", 32'(q0.size()), 32'd1);
      end else begin
        e0 = q0.pop_front();
        cmp("u0_frame{data,pe,fe,brk}", {20'd0, 1'b0, byte0, pe0, fe0, brk0}, {20'd0, e0});
      end
    end
    if (dv1) begin
      if (q1.size() == 0) begin
        cmp("u1_unexpected_dv_pending", 32'(q1.size()), 32'd1);
      end else begin
        e1 = q1.pop_front();
        cmp("u1_frame{data,pe,fe,brk}", {20'd0, 1'b0, byte1, pe1, fe1, brk1}, {20'd0, e1});
      end
    end
    if (dv2) begin
      if (q2.size() == 0) begin
        cmp("u2_unexpected_dv_pending", 32'(q2.size()), 32'd1);
      end else begin
        e2 = q2.pop_front();
        cmp("u2_frame{data,pe,fe,brk}", {20'd0, 2'b00, byte2, pe2, fe2, brk2}, {20'd0, e2});
      end
    end
  end

  task automatic probe(input string nm, input int id, input logic [31:0] exp);
    probe_t p;
    p.name = nm;
    p.id   = id;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  task automatic drive(input int inst, input logic v);
    case (inst)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // par < 0: no parity bit. glitch_pos: frame bit index (0 = start) that gets
  // inverted for one clock at offset 5, which lands on the middle vote sample.
  task automatic send_frame(input int inst, input logic [8:0] data, input int nd,
                            input int par, input logic [1:0] stops, input int nstop,
                            input int glitch_pos);
    logic [15:0] bits;
    int          n;
    logic        v;
    bits    = 16'h0000;
    n       = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < nd; i++) begin
      bits[n] = data[i];
      n++;
    end
    if (par >= 0) begin
      bits[n] = par[0];
      n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = stops[i];
      n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < C; c++) begin
        @(negedge clk);
        v = bits[b];
        if (b == glitch_pos && c == 5) v = ~v;
        drive(inst, v);
      end
    end
  endtask

  task automatic hold(input int inst, input logic v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      drive(inst, v);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    wait_cycles(4);
    probe("reset_u0_outputs", 0, 32'd0);
    probe("reset_u2_busy", 1, 32'd0);
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(2 * C);

    // 1. 8N1 back-to-back A5, 3C.
    q0.push_back('{data: 9'h0A5, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    q0.push_back('{data: 9'h03C, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send_frame(0, 9'h0A5, 8, -1, 2'b11, 1, -1);
    send_frame(0, 9'h03C, 8, -1, 2'b11, 1, -1);
    hold(0, 1'b1, 3 * C);

    // 2. 8E1: 0x37 has five ones, so even parity needs parity bit 1.
    q1.push_back('{data: 9'h037, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send_frame(1, 9'h037, 8, 1, 2'b11, 1, -1);
    hold(1, 1'b1, 2 * C);
    q1.push_back('{data: 9'h037, pe: 1'b1, fe: 1'b0, brk: 1'b0});
    send_frame(1, 9'h037, 8, 0, 2'b11, 1, -1);
    hold(1, 1'b1, 3 * C);

    // 3. 7O2: 0x41 has two ones, odd parity bit 1; second stop bit low.
    q2.push_back('{data: 9'h041, pe: 1'b0, fe: 1'b1, brk: 1'b0});
    send_frame(2, 9'h041, 7, 1, 2'b01, 2, -1);
    wait_cycles(2 * C);
    probe("u2_busy_in_wait_idle", 1, 32'd1);
    wait_cycles(2);
    hold(2, 1'b1, 6);
    probe("u2_busy_after_release", 1, 32'd0);
    wait_cycles(2 * C);

    // 4. Line held low for 30 bit times: one break frame, then 0x55.
    q0.push_back('{data: 9'h000, pe: 1'b0, fe: 1'b1, brk: 1'b1});
    hold(0, 1'b0, 30 * C);
    hold(0, 1'b1, 2 * C);
    q0.push_back('{data: 9'h055, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send_frame(0, 9'h055, 8, -1, 2'b11, 1, -1);
    hold(0, 1'b1, 3 * C);

    // 5. Start-bit glitch of 3 clocks, then 0xF0 with a 1-clock flip in bit 3.
    hold(0, 1'b0, 3);
    hold(0, 1'b1, 2);
    probe("u0_busy_during_glitch", 2, 32'd1);
    wait_cycles(3 * C);
    probe("u0_busy_after_glitch", 2, 32'd0);
    wait_cycles(2);
    q0.push_back('{data: 9'h0F0, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send_frame(0, 9'h0F0, 8, -1, 2'b11, 1, 4);
    hold(0, 1'b1, 3 * C);

    // 6. Reset in the middle of bit 4 of 0x81 (start 0, d0 1, d1..d4 0).
    hold(0, 1'b0, C);
    hold(0, 1'b1, C);
    hold(0, 1'b0, 3 * C + 6);
    @(negedge clk);
    rst = 1'b1;
    rx0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    probe("u0_outputs_after_midframe_reset", 0, 32'd0);
    wait_cycles(3 * C);
    q0.push_back('{data: 9'h081, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    send_frame(0, 9'h081, 8, -1, 2'b11, 1, -1);
    hold(0, 1'b1, 3 * C);

    // Every queued frame must have been delivered.
    probe("pending_frames_at_end", 3, 32'd0);
    wait_cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
